fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer on the consumer side of the program counter.
- Takes the current instruction-memory address from the PC.
- Issues a request to instruction memory and hands the returned word to decode over a valid/ready handshake.
- Drives the PC control strobes back: incPC (increment), loadPC (load) and selPC (jump target).

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The optional HALTED state exists only when FETCH_HALT_EN is defined.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 4;
    localparam int SEL_W   = 8;

    localparam logic [3:0] JMP_OPC  = 4'hF;
    localparam logic [3:0] HALT_OPC = 4'hE;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        UPDATE
`ifdef FETCH_HALT_EN
        ,
        HALTED
`endif
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(
        input logic [INSTR_W-1:0] w
    );
        return w[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC address -> imem request -> decode handshake -> PC strobes.
// Define FETCH_HALT_EN to stop fetching on a HALT opcode.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  ins_mem,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               incPC,
    output logic               loadPC,
    output logic [SEL_W-1:0]   selPC,
    output logic               halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        op;

    assign op = opcode_of(instr);

    // The PC only settles at the start of REQ, so the request cycle
    // forwards it directly; afterwards the issued address is held.
    assign imem_addr = imem_req ? ins_mem : addr_q;

`ifdef FETCH_HALT_EN
    logic halted_q;
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            addr_q      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            incPC       <= 1'b0;
            loadPC      <= 1'b0;
            selPC       <= '0;
`ifdef FETCH_HALT_EN
            halted_q    <= 1'b0;
`endif
        end else begin
            imem_req <= 1'b0;
            incPC    <= 1'b0;
            loadPC   <= 1'b0;
            if (imem_req) begin
                addr_q <= ins_mem;
            end
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= UPDATE;
                        if (op == JMP_OPC) begin
                            loadPC <= 1'b1;
                            selPC  <= instr[SEL_W-1:0];
                        end
`ifdef FETCH_HALT_EN
                        else if (op == HALT_OPC) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end
`endif
                        else begin
                            incPC <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
`ifdef FETCH_HALT_EN
                HALTED: begin
                    state <= HALTED;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a PC model and variable-latency memory.
// Covers the halt path when compiled with FETCH_HALT_EN.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDR_W-1:0]  ins_mem;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic               incPC;
    logic               loadPC;
    logic [SEL_W-1:0]   selPC;
    logic               halted;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ins_mem     (ins_mem),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .incPC       (incPC),
        .loadPC      (loadPC),
        .selPC       (selPC),
        .halted      (halted)
    );

    // Program counter model; bench can overwrite it without resetting.
    logic [3:0] pc = 4'h0;
    logic       pc_wr = 1'b0;
    logic [3:0] pc_val = 4'h0;
    assign ins_mem = pc;
    always @(posedge clk) begin
        if (pc_wr) pc <= pc_val;
        else if (loadPC) pc <= selPC[3:0];
        else if (incPC) pc <= pc + 4'd1;
    end

    // Memory with programmable latency, one outstanding read.
    logic [15:0] mem [16];
    int          lat = 1;
    int          cnt = 0;
    logic [3:0]  raddr = 4'h0;
    always @(posedge clk) begin
        if (imem_req) begin
            cnt   <= lat;
            raddr <= imem_addr;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign imem_valid = (cnt == 1);
    assign imem_rdata = mem[raddr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [3:0]  exp_req[$];
    logic [15:0] exp_ins[$];
    logic [8:0]  exp_stb[$];

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    int hs_cyc = 0;
    int req_cyc = 0;
    bit hs_seen = 0;
    bit prev_v = 0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (imem_req) begin
            if (exp_req.size() == 0) chk("spurious_req", 1, 0);
            else chk("req_addr", imem_addr, exp_req.pop_front());
            if (hs_seen) chk("hs_to_req", cyc - hs_cyc, 2);
            hs_seen = 0;
            req_cyc = cyc;
        end
        if (instr_valid && !prev_v)
            chk("req_to_valid", cyc - req_cyc, lat + 1);
        if (instr_valid && exp_ins.size() != 0)
            chk("instr", instr, exp_ins[0]);
        if (instr_valid && instr_ready) begin
            if (exp_ins.size() == 0) chk("spurious_hs", 1, 0);
            else void'(exp_ins.pop_front());
            hs_seen = 1;
            hs_cyc = cyc;
        end
        if (incPC || loadPC) begin
            chk("strobe_onehot", incPC & loadPC, 0);
            if (exp_stb.size() == 0) begin
                chk("spurious_strobe", 1, 0);
            end else begin
                e = exp_stb.pop_front();
                if (e[8]) chk("load", {loadPC, incPC, selPC}, {2'b10, e[7:0]});
                else chk("inc", {loadPC, incPC}, 2'b01);
            end
        end
        prev_v = instr_valid;
        if (rst) hs_seen = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string n);
        chk(n, {imem_req, imem_addr, instr, instr_valid,
                incPC, loadPC, selPC, halted}, 64'd0);
    endtask

    task automatic reset_phase(input bit setpc, input logic [3:0] p,
                               input int l);
        rst = 1'b1;
        instr_ready = 1'b0;
        lat = l;
        if (setpc) begin
            pc_wr = 1'b1;
            pc_val = p;
        end
        tick();
        pc_wr = 1'b0;
        tick();
        tick();
        chk_zero("reset_outs");
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((exp_req.size() + exp_ins.size() + exp_stb.size()) != 0
               && i < budget) begin
            tick();
            i++;
        end
        if ((exp_req.size() + exp_ins.size() + exp_stb.size()) != 0) begin
            chk("drain_timeout", 1, 0);
            exp_req.delete();
            exp_ins.delete();
            exp_stb.delete();
        end
    endtask

    task automatic wait_sig(input string n, input bit which, input int budget);
        int i = 0;
        while (!(which ? imem_req : instr_valid) && i < budget) begin
            tick();
            i++;
        end
        chk(n, which ? imem_req : instr_valid, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]  = 16'h1234;
        mem[1]  = 16'h2345;
        mem[2]  = 16'hF009;
        mem[3]  = 16'hE000;
        mem[9]  = 16'h3456;
        mem[10] = 16'h4567;
        mem[11] = 16'h0B0B;
        mem[15] = 16'h1111;

        // Sequential fetch, then a jump to 9.
        reset_phase(1, 4'h0, 1);
        exp_req = '{4'h0, 4'h1, 4'h2, 4'h9, 4'hA};
        exp_ins = '{16'h1234, 16'h2345, 16'hF009, 16'h3456};
        exp_stb = '{9'h000, 9'h000, 9'h109, 9'h000};
        instr_ready = 1'b1;
        wait_drain(200);
        instr_ready = 1'b0;

        // Slow memory and a stalled consumer; PC stays at 10.
        reset_phase(0, 4'h0, 4);
        exp_req = '{4'hA, 4'hB};
        exp_ins = '{16'h4567};
        exp_stb = '{9'h000};
        wait_sig("valid_arrives", 0, 30);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", {instr_valid, instr}, {1'b1, 16'h4567});
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_drain(40);

        // Reset lands on the cycle the read data returns.
        reset_phase(0, 4'h0, 1);
        exp_req = '{4'hB};
        wait_sig("req_seen", 1, 10);
        tick();
        chk("valid_in_wait", imem_valid, 1);
        rst = 1'b1;
        tick();
        chk_zero("reset_drop");
        tick();
        chk("drop_instr_valid", instr_valid, 0);
        exp_req = '{4'hB, 4'hC};
        exp_ins = '{16'h0B0B};
        exp_stb = '{9'h000};
        rst = 1'b0;
        instr_ready = 1'b1;
        wait_drain(60);
        instr_ready = 1'b0;

        // PC wrap from 15 to 0.
        reset_phase(1, 4'hF, 1);
        exp_req = '{4'hF, 4'h0};
        exp_ins = '{16'h1111};
        exp_stb = '{9'h000};
        instr_ready = 1'b1;
        wait_drain(60);
        instr_ready = 1'b0;

        // HALT opcode at address 3.
        reset_phase(1, 4'h3, 1);
        exp_req = '{4'h3};
        exp_ins = '{16'hE000};
`ifdef FETCH_HALT_EN
        instr_ready = 1'b1;
        wait_drain(60);
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("halted", {halted, imem_req, incPC, loadPC}, 4'b1000);
            tick();
        end
`else
        exp_req.push_back(4'h4);
        exp_stb = '{9'h000};
        instr_ready = 1'b1;
        wait_drain(60);
        chk("halted_tied", halted, 0);
`endif
        instr_ready = 1'b0;
        rst = 1'b1;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
